// File: rtl/deser_pkg.sv
// Shared types and default sizes for the deserializer queue controller.
package deser_pkg;

  localparam int BYTE_W      = 8;
  localparam int QUEUE_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    ACK,
    DRAIN
  } qctrl_state_t;

endpackage

// File: rtl/deser_queue_ctrl_byte_fifo.sv
// Plain synchronous DEPTH x WIDTH register FIFO with a separately tracked
// occupancy counter; the read port is registered.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     len_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    rd_data_d = rd_data_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en_i) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    // Length moves only when exactly one side is active.
    if (wr_en_i && !rd_en_i) begin
      len_d = len_q + 1'b1;
    end else if (!wr_en_i && rd_en_i) begin
      len_d = len_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      len_q     <= len_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;
  assign len_o     = len_q;
  assign full_o    = (len_q == LW'(DEPTH));
  assign empty_o   = (len_q == '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_en_i && !rd_en_i && full_o));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_en_i && empty_o));
  a_len_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    len_q <= LW'(DEPTH));

endmodule

// File: rtl/deser_queue_ctrl.sv
// Buffers bytes offered by the deserializer into a FIFO, returning its ack
// handshake, and serves single-cycle pop requests from the consumer.
module deser_queue_ctrl
  import deser_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic                   clock_100KHz,
  input  logic                   reset,
  input  logic                   des_data_ready,
  input  logic [WIDTH-1:0]       des_data,
  output logic                   des_ack,
  input  logic                   dequeue_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic [$clog2(DEPTH):0] len_out,
  output logic                   queue_full,
  output logic                   queue_empty,
  output logic                   underflow_out
);

  qctrl_state_t state_q, state_d;
  logic         ack_q, ack_d;
  logic         valid_q, valid_d;
  logic         underflow_q, underflow_d;
  logic         wr_en;
  logic         rd_en;
  logic         full;
  logic         empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (des_data_ready && !full) state_d = STORE;
      STORE:   state_d = ACK;
      ACK:     state_d = DRAIN;
      // Holding ack until data_ready falls keeps one byte from being stored twice.
      DRAIN:   if (!des_data_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d       = (state_d == ACK) || (state_d == DRAIN);
    valid_d     = rd_en;
    underflow_d = dequeue_in && empty;
  end

  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_en = (state_q == STORE);
  assign rd_en = dequeue_in && !empty;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i     (clock_100KHz),
    .rst_ni    (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (des_data),
    .rd_en_i   (rd_en),
    .rd_data_o (data_out),
    .len_o     (len_out),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign des_ack       = ack_q;
  assign data_valid    = valid_q;
  assign underflow_out = underflow_q;
  assign queue_full    = full;
  assign queue_empty   = empty;

endmodule

// File: tb/tb_deser_queue_ctrl.sv
// Self-checking bench for deser_queue_ctrl: a deserializer handshake model,
// a scoreboard of expected popped bytes, a vector table and corner sequences.
`timescale 1ns/1ps
module tb_deser_queue_ctrl;

  logic       clock_100KHz = 1'b0;
  logic       reset;
  logic       des_data_ready;
  logic [7:0] des_data;
  logic       des_ack;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] len_out;
  logic       queue_full;
  logic       queue_empty;
  logic       underflow_out;

  int         nVec = 0;
  int         nErr = 0;
  logic [7:0] expQ[$];
  logic [7:0] lastData;

  typedef struct {
    bit         isPush;
    logic [7:0] data;
    int         expLen;
    bit         expFull;
    bit         expEmpty;
  } vec_t;

  vec_t vecs[$];

  always #5 clock_100KHz = ~clock_100KHz;

  deser_queue_ctrl dut (
    .clock_100KHz   (clock_100KHz),
    .reset          (reset),
    .des_data_ready (des_data_ready),
    .des_data       (des_data),
    .des_ack        (des_ack),
    .dequeue_in     (dequeue_in),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .len_out        (len_out),
    .queue_full     (queue_full),
    .queue_empty    (queue_empty),
    .underflow_out  (underflow_out)
  );

  // Compare one observed value to its bench-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitAckLow();
    int cnt = 0;
    while (des_ack && cnt < 50) begin
      @(negedge clock_100KHz);
      cnt++;
    end
    checkOutput("ackDrop", des_ack, 0);
  endtask

  // Deserializer model: raise data_ready, drop it one cycle after seeing ack.
  task automatic deliverByte(input logic [7:0] b, input bit checkLat);
    int cnt = 0;
    @(negedge clock_100KHz);
    des_data       = b;
    des_data_ready = 1'b1;
    expQ.push_back(b);
    while (!des_ack && cnt < 50) begin
      @(negedge clock_100KHz);
      cnt++;
    end
    if (!des_ack) checkOutput("ackSeen", des_ack, 1);
    else if (checkLat) checkOutput("ackLatency", cnt, 2);
    @(negedge clock_100KHz);
    des_data_ready = 1'b0;
    waitAckLow();
  endtask

  task automatic checkPopped(input string name);
    checkOutput({name, "Valid"}, data_valid, 1);
    if (expQ.size() == 0) begin
      nVec++;
      nErr++;
      $display("[TB] FAIL %s: scoreboard empty, got %0h", name, data_out);
    end else begin
      lastData = expQ.pop_front();
      checkOutput({name, "Data"}, data_out, lastData);
    end
  endtask

  task automatic popCheck(input string name);
    @(negedge clock_100KHz);
    dequeue_in = 1'b1;
    @(negedge clock_100KHz);
    dequeue_in = 1'b0;
    checkPopped(name);
  endtask

  // STORE of b lands on the same edge as a pop of the oldest entry.
  task automatic pushPopTogether(input logic [7:0] b, input int expLen);
    @(negedge clock_100KHz);
    des_data       = b;
    des_data_ready = 1'b1;
    expQ.push_back(b);
    @(negedge clock_100KHz);
    dequeue_in = 1'b1;
    @(negedge clock_100KHz);
    dequeue_in = 1'b0;
    checkOutput("simAck", des_ack, 1);
    checkPopped("simPop");
    checkOutput("simLen", len_out, expLen);
    @(negedge clock_100KHz);
    des_data_ready = 1'b0;
    waitAckLow();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isPush) deliverByte(v.data, 1'b0);
    else popCheck("tblPop");
    checkOutput("tblLen", len_out, v.expLen);
    checkOutput("tblFull", queue_full, v.expFull);
    checkOutput("tblEmpty", queue_empty, v.expEmpty);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit held;

    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 8'(i + 1), i + 1, (i == 7), 1'b0});

    reset          = 1'b0;
    des_data_ready = 1'b0;
    des_data       = 8'h00;
    dequeue_in     = 1'b0;
    lastData       = 8'h00;
    repeat (2) @(negedge clock_100KHz);
    checkOutput("rstAck", des_ack, 0);
    checkOutput("rstData", data_out, 0);
    checkOutput("rstValid", data_valid, 0);
    checkOutput("rstUnder", underflow_out, 0);
    checkOutput("rstLen", len_out, 0);
    checkOutput("rstEmpty", queue_empty, 1);
    checkOutput("rstFull", queue_full, 0);
    reset = 1'b1;

    // Single byte round trip.
    deliverByte(8'hA5, 1'b1);
    checkOutput("oneLen", len_out, 1);
    popCheck("onePop");
    checkOutput("oneLenAfter", len_out, 0);
    checkOutput("oneEmpty", queue_empty, 1);

    // Fill to full, then backpressure a ninth byte.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    @(negedge clock_100KHz);
    des_data       = 8'h09;
    des_data_ready = 1'b1;
    expQ.push_back(8'h09);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_100KHz);
      if (des_ack) held = 1'b0;
    end
    checkOutput("bpAckHeld", held, 1);
    checkOutput("bpLen", len_out, 8);
    popCheck("bpPop");
    cnt = 0;
    while (!des_ack && cnt < 50) begin
      @(negedge clock_100KHz);
      cnt++;
    end
    checkOutput("bpAckAfterPop", des_ack, 1);
    @(negedge clock_100KHz);
    des_data_ready = 1'b0;
    waitAckLow();
    checkOutput("bpLenRefill", len_out, 8);
    checkOutput("bpFullRefill", queue_full, 1);
    for (int i = 0; i < 8; i++) applyStimulus('{1'b0, 8'h00, 7 - i, 1'b0, (i == 7)});

    // Wrap-around with push/pop pairs.
    for (int i = 0; i < 12; i++) begin
      deliverByte(8'(8'h10 + i), 1'b0);
      popCheck("wrapPop");
      checkOutput("wrapLen", len_out, 0);
    end

    // Coincident STORE and pop, at len 3 and at len 1.
    deliverByte(8'h20, 1'b0);
    deliverByte(8'h21, 1'b0);
    deliverByte(8'h22, 1'b0);
    pushPopTogether(8'h55, 3);
    for (int i = 0; i < 3; i++) popCheck("simDrain");
    checkOutput("simEmpty", queue_empty, 1);
    deliverByte(8'h66, 1'b0);
    pushPopTogether(8'h77, 1);
    popCheck("simLast");
    checkOutput("simLenEnd", len_out, 0);

    // Underflow on an empty queue.
    @(negedge clock_100KHz);
    dequeue_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock_100KHz);
      checkOutput("ufPulse", underflow_out, 1);
      checkOutput("ufValid", data_valid, 0);
      checkOutput("ufData", data_out, lastData);
      checkOutput("ufLen", len_out, 0);
    end
    dequeue_in = 1'b0;
    @(negedge clock_100KHz);
    checkOutput("ufClear", underflow_out, 0);

    // Reset while in DRAIN with four entries.
    deliverByte(8'h30, 1'b0);
    deliverByte(8'h31, 1'b0);
    deliverByte(8'h32, 1'b0);
    @(negedge clock_100KHz);
    des_data       = 8'h33;
    des_data_ready = 1'b1;
    cnt = 0;
    while (!des_ack && cnt < 50) begin
      @(negedge clock_100KHz);
      cnt++;
    end
    @(posedge clock_100KHz);
    #2;
    checkOutput("midAck", des_ack, 1);
    checkOutput("midLen", len_out, 4);
    reset = 1'b0;
    #1;
    checkOutput("midRstAck", des_ack, 0);
    checkOutput("midRstLen", len_out, 0);
    checkOutput("midRstEmpty", queue_empty, 1);
    checkOutput("midRstData", data_out, 0);
    des_data_ready = 1'b0;
    expQ.delete();
    @(negedge clock_100KHz);
    reset = 1'b1;
    deliverByte(8'h3C, 1'b1);
    checkOutput("postLen", len_out, 1);
    popCheck("postPop");
    checkOutput("postEmpty", queue_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
